// File: rtl/proc_mem_pkg.sv
// proc_mem_pkg: shared types and constants for the processor memory arbiter
package proc_mem_pkg;
  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
  localparam int PM_DATA_W = 64;
  localparam int PM_BE_W = 8;
  localparam int PM_LAT_CNT_W = 3;
endpackage

// File: rtl/proc_mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick, one-hot grant (bit 0 = fetch, bit 1 = load/store)
module rr_arb2
  import proc_mem_pkg::*;
(
  input  logic       req_if,
  input  logic       req_d,
  input  owner_t     last_gnt,
  output logic [1:0] gnt
);
  always_comb gnt = (req_if && req_d) ? ((last_gnt == OWN_D) ? 2'b01 : 2'b10) : {req_d, req_if};
endmodule

// File: rtl/proc_mem_arbiter.sv
// proc_mem_arbiter: shares one single-port memory between fetch and load/store ports
module proc_mem_arbiter
  import proc_mem_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = PM_DATA_W,
  parameter int MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);
  localparam logic [PM_LAT_CNT_W-1:0] LAT_INIT = PM_LAT_CNT_W'(MEM_LAT - 1);
  arb_state_t state, state_nx;
  owner_t owner, owner_nx, last_gnt, last_gnt_nx;
  logic [PM_LAT_CNT_W-1:0] lat_cnt, lat_cnt_nx;
  logic [1:0] pick;
  logic idle, win_if, win_d, rd, resp, store;
  rr_arb2 u_arb (.req_if(if_req_i), .req_d(d_req_i), .last_gnt(last_gnt), .gnt(pick));
  always_comb begin
    idle        = !rst && state == ARB_IDLE;
    win_if      = idle && pick[0];
    win_d       = idle && pick[1];
    store       = win_d && d_we_i;
    rd          = win_if || (win_d && !d_we_i);
    resp        = !rst && state == ARB_WAIT && lat_cnt == '0;
    if_gnt_o    = win_if;
    d_gnt_o     = win_d;
    mem_req_o   = win_if || win_d;
    mem_we_o    = store;
    mem_addr_o  = win_if ? if_addr_i : win_d ? d_addr_i : '0;
    mem_wdata_o = store ? d_wdata_i : '0;
    mem_be_o    = store ? d_be_i : rd ? '1 : '0;
    if_rvalid_o = resp && owner == OWN_IF;
    d_rvalid_o  = resp && owner == OWN_D;
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;
    state_nx    = resp ? ARB_IDLE : rd ? ARB_WAIT : state;
    owner_nx    = rd ? (win_if ? OWN_IF : OWN_D) : owner;
    last_gnt_nx = win_if ? OWN_IF : win_d ? OWN_D : last_gnt;
    lat_cnt_nx  = rd ? LAT_INIT : (state == ARB_WAIT && lat_cnt != '0) ? lat_cnt - 1'b1 : lat_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      lat_cnt  <= '0;
      last_gnt <= OWN_D;
      owner    <= OWN_IF;
    end else begin
      state    <= state_nx;
      lat_cnt  <= lat_cnt_nx;
      last_gnt <= last_gnt_nx;
      owner    <= owner_nx;
    end
  end
endmodule

// File: tb/tb_proc_mem_arbiter.sv
// tb_proc_mem_arbiter: randomized and directed check of two arbiter instances (latency 1 and 3) against a timestamp model
module tb_proc_mem_arbiter;
  logic clk;
  logic rst [2];
  logic if_req [2], d_req [2], d_we [2];
  logic [63:0] if_addr [2], d_addr [2], d_wdata [2], mem_rdata [2];
  logic [7:0] d_be [2];
  logic if_gnt [2], if_rvalid [2], d_gnt [2], d_rvalid [2], mem_req [2], mem_we [2];
  logic [63:0] if_rdata [2], d_rdata [2], mem_addr [2], mem_wdata [2];
  logic [7:0] mem_be [2];
  int n_cmp = 0, n_err = 0, cyc = 0;
  int m_free [2], m_resp [2], m_rown [2], m_last [2];
  logic eg_if [2], eg_d [2];
  for (genvar g = 0; g < 2; g++) begin : g_dut
    proc_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(g == 0 ? 1 : 3)) dut (
      .clk(clk), .rst(rst[g]),
      .if_req_i(if_req[g]), .if_addr_i(if_addr[g]), .if_gnt_o(if_gnt[g]),
      .if_rvalid_o(if_rvalid[g]), .if_rdata_o(if_rdata[g]),
      .d_req_i(d_req[g]), .d_we_i(d_we[g]), .d_addr_i(d_addr[g]), .d_wdata_i(d_wdata[g]),
      .d_be_i(d_be[g]), .d_gnt_o(d_gnt[g]), .d_rvalid_o(d_rvalid[g]), .d_rdata_o(d_rdata[g]),
      .mem_req_o(mem_req[g]), .mem_we_o(mem_we[g]), .mem_addr_o(mem_addr[g]),
      .mem_wdata_o(mem_wdata[g]), .mem_be_o(mem_be[g]), .mem_rdata_i(mem_rdata[g])
    );
  end
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input int k, input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d] cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
    end
  endtask
  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int lat = (k == 0) ? 1 : 3;
      int win = -1;
      logic rv = 0, we = 0;
      logic [63:0] e_addr = 0, e_wd = 0;
      logic [7:0] e_be = 0;
      if (rst[k]) begin
        m_free[k] = cyc + 1;
        m_resp[k] = -1;
        m_last[k] = 1;
      end else begin
        rv = (cyc == m_resp[k]);
        if (cyc >= m_free[k])
          win = (if_req[k] && d_req[k]) ? ((m_last[k] == 1) ? 0 : 1) : if_req[k] ? 0 : d_req[k] ? 1 : -1;
        if (win == 0) begin
          e_addr = if_addr[k];
          e_be = 8'hFF;
        end else if (win == 1) begin
          we = d_we[k];
          e_addr = d_addr[k];
          e_be = we ? d_be[k] : 8'hFF;
          e_wd = we ? d_wdata[k] : 64'h0;
        end
        if (win >= 0) begin
          m_last[k] = win;
          if (we) m_free[k] = cyc + 1;
          else begin
            m_resp[k] = cyc + lat;
            m_rown[k] = win;
            m_free[k] = cyc + lat + 1;
          end
        end
      end
      eg_if[k] = (win == 0);
      eg_d[k] = (win == 1);
      chk(k, "if_gnt", if_gnt[k], eg_if[k]);
      chk(k, "d_gnt", d_gnt[k], eg_d[k]);
      chk(k, "mem_req", mem_req[k], win >= 0);
      chk(k, "mem_we", mem_we[k], we);
      chk(k, "mem_addr", mem_addr[k], e_addr);
      chk(k, "mem_wdata", mem_wdata[k], e_wd);
      chk(k, "mem_be", mem_be[k], e_be);
      chk(k, "if_rvalid", if_rvalid[k], rv && m_rown[k] == 0);
      chk(k, "d_rvalid", d_rvalid[k], rv && m_rown[k] == 1);
      chk(k, "if_rdata", if_rdata[k], (rv && m_rown[k] == 0) ? mem_rdata[k] : 64'h0);
      chk(k, "d_rdata", d_rdata[k], (rv && m_rown[k] == 1) ? mem_rdata[k] : 64'h0);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (eg_if[k]) if_req[k] = 0;
      if (eg_d[k]) d_req[k] = 0;
    end
  endtask
  task automatic rand_step(input int k);
    if (!if_req[k] && $urandom_range(1, 0) == 1) begin
      if_req[k] = 1;
      if_addr[k] = {$urandom(), $urandom()};
    end
    if (!d_req[k] && $urandom_range(1, 0) == 1) begin
      d_req[k] = 1;
      d_we[k] = $urandom_range(1, 0) == 1;
      d_addr[k] = {$urandom(), $urandom()};
      d_wdata[k] = {$urandom(), $urandom()};
      d_be[k] = 8'($urandom());
    end
    mem_rdata[k] = {$urandom(), $urandom()};
    rst[k] = $urandom_range(63, 0) == 0;
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1; if_req[k] = 1; d_req[k] = 1; d_we[k] = 0;
      if_addr[k] = 64'h40; d_addr[k] = 64'h80; d_wdata[k] = 64'h1111; d_be[k] = 8'h3C;
      mem_rdata[k] = 64'hA5A5_0000_5A5A_0001 + 64'(k);
      m_free[k] = 0; m_resp[k] = -1; m_rown[k] = 0; m_last[k] = 1;
      eg_if[k] = 0; eg_d[k] = 0;
    end
    tick(); tick();
    rst[0] = 0; rst[1] = 0;
    repeat (8) tick();
    if_req[0] = 1; if_addr[0] = 64'h10;
    tick();
    mem_rdata[0] = 64'h0000_0013_0000_0093;
    tick(); tick();
    if_addr[0] = 64'h200; d_addr[0] = 64'h300; d_we[0] = 0;
    for (int i = 0; i < 9; i++) begin
      if_req[0] = 1; d_req[0] = 1;
      mem_rdata[0] = 64'hC0DE_0000_0000_0000 + 64'(i);
      tick();
    end
    if_req[0] = 0; d_req[0] = 0;
    repeat (3) tick();
    if_req[0] = 1; if_addr[0] = 64'h20;
    tick(); tick(); tick();
    if_req[0] = 1; d_req[0] = 1; d_we[0] = 1;
    d_addr[0] = 64'h100; d_wdata[0] = 64'hDEAD_BEEF_CAFE_F00D; d_be[0] = 8'h0F;
    tick(); tick(); tick(); tick();
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 64'h180;
    tick();
    rst[0] = 1; if_req[0] = 1; if_addr[0] = 64'h28;
    tick();
    rst[0] = 0;
    tick(); tick(); tick();
    if_req[1] = 1; if_addr[1] = 64'h400;
    tick();
    d_req[1] = 1; d_we[1] = 0; d_addr[1] = 64'h480;
    repeat (7) tick();
    for (int i = 0; i < 600; i++) begin
      rand_step(0);
      rand_step(1);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
